// File: rtl/soc_lite_top.sv
// SoC-lite top-level glue: clock nets, the confreg register file and the
// board GPIO (LEDs, 7-segment display, switches, buttons, key matrix).

module confreg #(
  parameter bit SIMULATION = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        conf_en,
  input  logic [3:0]  conf_wen,
  input  logic [31:0] conf_addr,
  input  logic [31:0] conf_wdata,
  output logic [31:0] conf_rdata,
  output logic [15:0] led,
  output logic [1:0]  led_rg0,
  output logic [1:0]  led_rg1,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  input  logic [7:0]  switch,
  input  logic [3:0]  btn_key_row,
  input  logic [1:0]  btn_step
);

  localparam int SCAN_W = SIMULATION ? 4 : 20;

  logic [31:0]       cr [8];
  logic [31:0]       timer;
  logic [15:0]       led_data;
  logic [31:0]       num_data;
  logic              open_trace;
  logic              num_monitor;
  logic              write_uart_valid;
  logic [7:0]        write_uart_data;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        sel;
  logic [15:0]       off;
  logic              wr_en;
  logic              rd_en;
  logic              cr_hit;
  logic [31:0]       rd_mux;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  wen);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = wen[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
    endcase
    return s;
  endfunction

  assign off    = conf_addr[15:0];
  assign wr_en  = conf_en && (conf_wen != 4'h0);
  assign rd_en  = conf_en && (conf_wen == 4'h0);
  // CR0..CR7 occupy word-aligned offsets 0x8000..0x801C
  assign cr_hit = (off[15:5] == 11'h400) && (off[1:0] == 2'b00);

  assign led     = led_data;
  assign sel     = scan_cnt[SCAN_W-1 -: 3];
  assign num_csn = ~(8'b1 << sel);
  assign num_a_g = hex2seg(num_data[{sel, 2'b00} +: 4]);

  // General-purpose scratch registers CR0..CR7
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) cr[i] <= 32'h0;
    end else if (wr_en && cr_hit) begin
      cr[off[4:2]] <= byte_merge(cr[off[4:2]], conf_wdata, conf_wen);
    end
  end

  // Free-running timer; a write in the same cycle overrides the increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= 32'h0;
    end else if (wr_en && off == 16'hE000) begin
      timer <= byte_merge(timer, conf_wdata, conf_wen);
    end else begin
      timer <= timer + 32'h1;
    end
  end

  // GPIO and simulation-control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_data    <= 16'hFFFF;
      led_rg0     <= 2'b00;
      led_rg1     <= 2'b00;
      num_data    <= 32'h0;
      open_trace  <= 1'b1;
      num_monitor <= 1'b1;
    end else if (wr_en) begin
      case (off)
        16'hF000: begin
          if (conf_wen[0]) led_data[7:0]  <= conf_wdata[7:0];
          if (conf_wen[1]) led_data[15:8] <= conf_wdata[15:8];
        end
        16'hF004: if (conf_wen[0]) led_rg0 <= conf_wdata[1:0];
        16'hF008: if (conf_wen[0]) led_rg1 <= conf_wdata[1:0];
        16'hF010: num_data <= byte_merge(num_data, conf_wdata, conf_wen);
        16'hFFF8: if (conf_wen[0]) open_trace  <= conf_wdata[0];
        16'hFFFC: if (conf_wen[0]) num_monitor <= conf_wdata[0];
        default: ;
      endcase
    end
  end

  // Virtual UART: one-cycle strobe per byte written
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_uart_valid <= 1'b0;
      write_uart_data  <= 8'h0;
    end else begin
      write_uart_valid <= wr_en && conf_wen[0] && (off == 16'hFFF0);
      if (wr_en && conf_wen[0] && (off == 16'hFFF0)) write_uart_data <= conf_wdata[7:0];
    end
  end

  // Read-data multiplexer over the register map
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      16'hE000: rd_mux = timer;
      16'hF000: rd_mux = {16'h0, led_data};
      16'hF004: rd_mux = {30'h0, led_rg0};
      16'hF008: rd_mux = {30'h0, led_rg1};
      16'hF010: rd_mux = num_data;
      16'hF020: rd_mux = {24'h0, switch};
      16'hF024: rd_mux = {28'h0, ~btn_key_row};
      16'hF028: rd_mux = {30'h0, ~btn_step};
      16'hFFF4: rd_mux = {32{SIMULATION}};
      16'hFFF8: rd_mux = {31'h0, open_trace};
      16'hFFFC: rd_mux = {31'h0, num_monitor};
      default:  if (cr_hit) rd_mux = cr[off[4:2]];
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conf_rdata <= 32'h0;
    end else if (rd_en) begin
      conf_rdata <= rd_mux;
    end
  end

  // 7-segment scan counter; top three bits select the active digit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

module soc_lite_top #(
  parameter bit SIMULATION = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        cpu_clk,
  input  logic        conf_en,
  input  logic [3:0]  conf_wen,
  input  logic [31:0] conf_addr,
  input  logic [31:0] conf_wdata,
  output logic [31:0] conf_rdata,
  output logic [15:0] led,
  output logic [1:0]  led_rg0,
  output logic [1:0]  led_rg1,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  input  logic [7:0]  switch,
  output logic [3:0]  btn_key_col,
  input  logic [3:0]  btn_key_row,
  input  logic [1:0]  btn_step
);

  logic sys_clk;

  assign sys_clk     = clk;
  assign cpu_clk     = clk;
  assign btn_key_col = 4'b0000;

  confreg #(.SIMULATION(SIMULATION)) u_confreg (
    .clk         (sys_clk),
    .resetn      (resetn),
    .conf_en     (conf_en),
    .conf_wen    (conf_wen),
    .conf_addr   (conf_addr),
    .conf_wdata  (conf_wdata),
    .conf_rdata  (conf_rdata),
    .led         (led),
    .led_rg0     (led_rg0),
    .led_rg1     (led_rg1),
    .num_csn     (num_csn),
    .num_a_g     (num_a_g),
    .switch      (switch),
    .btn_key_row (btn_key_row),
    .btn_step    (btn_step)
  );

endmodule

// File: tb/tb_soc_lite_top.sv
// Scoreboard bench for soc_lite_top (simulation build): randomized register
// traffic checked against a register-map model kept in the bench.

module tb_soc_lite_top;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_clk;
  logic        conf_en = 1'b0;
  logic [3:0]  conf_wen = 4'h0;
  logic [31:0] conf_addr = 32'h0;
  logic [31:0] conf_wdata = 32'h0;
  logic [31:0] conf_rdata;
  logic [15:0] led;
  logic [1:0]  led_rg0, led_rg1;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;
  logic [7:0]  switch = 8'h0;
  logic [3:0]  btn_key_col;
  logic [3:0]  btn_key_row = 4'hF;
  logic [1:0]  btn_step = 2'b11;

  soc_lite_top #(.SIMULATION(1'b1)) dut (
    .clk(clk), .resetn(resetn), .cpu_clk(cpu_clk),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
    .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
    .led(led), .led_rg0(led_rg0), .led_rg1(led_rg1),
    .num_csn(num_csn), .num_a_g(num_a_g), .switch(switch),
    .btn_key_col(btn_key_col), .btn_key_row(btn_key_row), .btn_step(btn_step)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cr [8];
  logic [15:0] m_led;
  logic [1:0]  m_rg0, m_rg1;
  logic [31:0] m_num;
  logic        m_trace, m_mon;
  logic [31:0] m_tload;          // timer value at the last load/reset
  int          m_tcyc;           // cycle count at which m_tload took effect
  int          cyc = 0;          // clock edges seen out of reset

  logic [31:0] rq[$];            // expected read data
  logic [7:0]  uq[$];            // expected UART bytes
  logic [31:0] rd_log[$];        // observed read data
  logic [6:0]  seg_tab [16];

  always @(posedge clk) if (resetn) cyc <= cyc + 1;

  function automatic logic [31:0] mask_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] wen);
    logic [31:0] m;
    m = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] model_timer();
    return m_tload + 32'(cyc - m_tcyc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cr[i] = 32'h0;
    m_led = 16'hFFFF; m_rg0 = 2'b00; m_rg1 = 2'b00; m_num = 32'h0;
    m_trace = 1'b1; m_mon = 1'b1; m_tload = 32'h0; m_tcyc = cyc;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    int idx;
    case (a)
      16'hE000: return model_timer();
      16'hF000: return {16'h0, m_led};
      16'hF004: return {30'h0, m_rg0};
      16'hF008: return {30'h0, m_rg1};
      16'hF010: return m_num;
      16'hF020: return {24'h0, switch};
      16'hF024: return {28'h0, ~btn_key_row};
      16'hF028: return {30'h0, ~btn_step};
      16'hFFF4: return 32'hFFFF_FFFF;
      16'hFFF8: return {31'h0, m_trace};
      16'hFFFC: return {31'h0, m_mon};
      default: begin
        if (a >= 16'h8000 && a <= 16'h801C && a[1:0] == 2'b00) begin
          idx = (int'(a) - 32'h8000) / 4;
          return m_cr[idx];
        end
        return 32'h0;
      end
    endcase
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] wen);
    logic [31:0] t;
    int idx;
    case (a)
      16'hE000: begin m_tload = mask_merge(model_timer(), d, wen); m_tcyc = cyc + 1; end
      16'hF000: begin t = mask_merge({16'h0, m_led}, d, wen); m_led = t[15:0]; end
      16'hF004: if (wen[0]) m_rg0 = d[1:0];
      16'hF008: if (wen[0]) m_rg1 = d[1:0];
      16'hF010: m_num = mask_merge(m_num, d, wen);
      16'hFFF0: if (wen[0]) uq.push_back(d[7:0]);
      16'hFFF8: if (wen[0]) m_trace = d[0];
      16'hFFFC: if (wen[0]) m_mon = d[0];
      default: begin
        if (a >= 16'h8000 && a <= 16'h801C && a[1:0] == 2'b00) begin
          idx = (int'(a) - 32'h8000) / 4;
          m_cr[idx] = mask_merge(m_cr[idx], d, wen);
        end
      end
    endcase
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    if (resetn && conf_en && conf_wen == 4'h0) begin
      #1;
      if (rq.size() == 0) begin
        n_total++;
        $display("FAIL rdata_unexpected: got 0x%08h, expected no read", conf_rdata);
      end else begin
        check("rdata", conf_rdata, rq.pop_front());
        rd_log.push_back(conf_rdata);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (dut.u_confreg.write_uart_valid === 1'b1) begin
      if (uq.size() == 0) begin
        n_total++;
        $display("FAIL uart_unexpected: got valid with 0x%02h, expected no pulse",
                 dut.u_confreg.write_uart_data);
      end else begin
        check("uart_data", {24'h0, dut.u_confreg.write_uart_data}, {24'h0, uq.pop_front()});
      end
    end
  end

  // ---------------- stimulus tasks (called at a negedge) ----------------
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] wen);
    conf_en = 1'b1; conf_wen = wen; conf_wdata = d;
    conf_addr = {16'($urandom), a};
    model_write(a, d, wen);
    @(negedge clk);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("led_rg", {28'h0, led_rg1, led_rg0}, {28'h0, m_rg1, m_rg0});
    check("num_data", dut.u_confreg.num_data, m_num);
    check("trace_mon", {30'h0, dut.u_confreg.open_trace, dut.u_confreg.num_monitor},
          {30'h0, m_trace, m_mon});
  endtask

  task automatic rd(input logic [15:0] a);
    conf_en = 1'b1; conf_wen = 4'h0; conf_wdata = $urandom;
    conf_addr = {16'($urandom), a};
    rq.push_back(model_read(a));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    conf_en = 1'b0; conf_wen = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_check(input int ncyc, output int slot0);
    int d;
    logic [7:0] one;
    slot0 = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      d = -1;
      for (int k = 0; k < 8; k++) begin
        one = 8'd1 << k;
        if (num_csn == ~one) d = k;
      end
      n_total++;
      if (d < 0) begin
        $display("FAIL csn_onehot: got 0x%02h, expected one-low digit select", num_csn);
      end else begin
        n_pass++;
        check("num_a_g", {25'h0, num_a_g}, {25'h0, seg_tab[m_num[d*4 +: 4]]});
        if (d == 0) slot0++;
      end
    end
  endtask

  logic [15:0] addr_tab [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    logic [15:0] a;
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    addr_tab = '{16'h8000, 16'h8004, 16'h800C, 16'h801C, 16'hE000, 16'hF000,
                 16'hF004, 16'hF008, 16'hF010, 16'hF020, 16'hF024, 16'hF028,
                 16'hFFF0, 16'hFFF4, 16'hFFF8, 16'hFFFC, 16'h8002, 16'h1234};

    // reset
    resetn = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_led", {16'h0, led}, 32'h0000FFFF);
    check("reset_rg", {28'h0, led_rg1, led_rg0}, 32'h0);
    check("key_col", {28'h0, btn_key_col}, 32'h0);
    resetn = 1'b1;
    model_reset();
    rd(16'hF010); rd(16'hFFF8); rd(16'hFFFC); rd(16'hF000); rd(16'hFFF4);
    idle(1);

    // NUM write and readback
    wr(16'hF010, 32'h01000001, 4'hF);
    rd(16'hF010);
    idle(1);
    check("num_probe", dut.u_confreg.num_data, 32'h01000001);
    wr(16'h8004, 32'hDEADBEEF, 4'hF);
    idle(1);
    check("rdata_hold", conf_rdata, 32'h01000001);

    // LED byte enables
    wr(16'hF000, 32'h12345678, 4'b0001);
    check("led_b0", {16'h0, led}, 32'h0000FF78);
    wr(16'hF000, 32'h0000AB00, 4'b0010);
    check("led_b1", {16'h0, led}, 32'h0000AB78);

    // virtual UART
    wr(16'hFFF0, 32'h00000041, 4'hF); idle(3);
    wr(16'hFFF0, 32'h000000FF, 4'h1); idle(3);
    wr(16'hFFF0, 32'h0000005A, 4'h1);
    wr(16'hFFF0, 32'h000000A5, 4'h1); idle(3);
    wr(16'hFFF0, 32'h00000077, 4'h2); idle(3);
    check("uart_drained", uq.size(), 0);

    // timer
    rd(16'hE000); idle(9); rd(16'hE000); idle(1);
    check("timer_delta", rd_log[rd_log.size()-1] - rd_log[rd_log.size()-2], 32'd10);
    wr(16'hE000, 32'hFFFFFFFF, 4'hF);
    rd(16'hE000); rd(16'hE000); idle(1);
    check("timer_wrap", rd_log[rd_log.size()-1], 32'h0);

    // 7-segment scan: digit 0 shows F, others 0; each slot lasts 2 cycles
    wr(16'hF010, 32'h0000000F, 4'hF);
    idle(0);
    scan_check(32, s0);
    check("slot0_cycles", s0, 4);
    wr(16'hF010, $urandom, 4'hF);
    idle(0);
    scan_check(16, s0);

    // randomized register traffic
    for (int i = 0; i < 250; i++) begin
      switch = 8'($urandom); btn_key_row = 4'($urandom); btn_step = 2'($urandom);
      a = addr_tab[$urandom_range(0, 17)];
      if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(1, 15)));
      else rd(a);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // asynchronous reset mid-count
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async_timer", dut.u_confreg.timer, 32'h0);
    check("async_led", {16'h0, led}, 32'h0000FFFF);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    rd(16'hE000); rd(16'hFFF8); rd(16'hF010);
    idle(3);

    check("rq_drained", rq.size(), 0);
    check("uq_drained", uq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
